// File: rtl/vga_timing_gen_if.sv
// Bundle between the VGA timing stage and its consumers: the pixel-advance strobe in,
// sync, blanking, coordinates and line/frame pulses out.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          pixel_en;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pixel_en,
        input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        input  pixel_en,
        output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator: advances one pixel per pixel_en strobe and registers
// coordinates, sync, blanking and start pulses together so they never skew.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic             clock_in,
    input  logic             reset_n,
    vga_timing_gen_if.slave  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Output decode is a pure function of position, so it can be applied to the
    // next-position wires and registered on the same edge as the counters.
    function automatic logic hs_of(input logic [CW-1:0] x);
        return ((int'(x) >= HS_BEG) && (int'(x) < HS_END)) ? HS_POL : ~HS_POL;
    endfunction

    function automatic logic vs_of(input logic [CW-1:0] y);
        return ((int'(y) >= VS_BEG) && (int'(y) < VS_END)) ? VS_POL : ~VS_POL;
    endfunction

    function automatic logic von_of(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_hs;
    logic          r_vs;
    logic          r_von;
    logic          r_ls;
    logic          r_fs;

    logic          w_x_wrap;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;

    assign w_x_wrap = (r_x == X_LAST);
    assign w_x_nxt  = w_x_wrap ? '0 : r_x + CW'(1);
    assign w_y_nxt  = w_x_wrap ? ((r_y == Y_LAST) ? '0 : r_y + CW'(1)) : r_y;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_von   <= 1'b0;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            // Pulses fall on every clock unless this strobe lands on x = 0.
            r_ls <= 1'b0;
            r_fs <= 1'b0;
            if (vga.pixel_en) begin
                case (r_state)
                    IDLE: begin
                        // First strobe presents (0,0) without advancing the counters.
                        r_state <= RUN;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_hs    <= hs_of('0);
                        r_vs    <= vs_of('0);
                        r_von   <= von_of('0, '0);
                        r_ls    <= 1'b1;
                        r_fs    <= 1'b1;
                    end
                    RUN: begin
                        r_x   <= w_x_nxt;
                        r_y   <= w_y_nxt;
                        r_hs  <= hs_of(w_x_nxt);
                        r_vs  <= vs_of(w_y_nxt);
                        r_von <= von_of(w_x_nxt, w_y_nxt);
                        r_ls  <= (w_x_nxt == '0);
                        r_fs  <= (w_x_nxt == '0) && (w_y_nxt == '0);
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign vga.pixel_x     = r_x;
    assign vga.pixel_y     = r_y;
    assign vga.hsync       = r_hs;
    assign vga.vsync       = r_vs;
    assign vga.video_on    = r_von;
    assign vga.line_start  = r_ls;
    assign vga.frame_start = r_fs;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Sync/timing stage directly downstream of clock_divider in the VGA signal-timing path.
- Runs on the 50 MHz system clock and advances one pixel per pixel_en strobe (the divided pixel rate, 25 MHz for DIVISOR 2).
- Produces hsync, vsync, video_on, pixel coordinates and line/frame start pulses for the pixel generators and game logic.
- Default timing is 640x480 @ 60 Hz.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync (0 = active-low)
- CW, 10, width of coordinate counters

Ports:
- clock_in  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous active-low reset
- pixel_en  input  1  one-clock pixel-advance strobe from the divider stage
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high while (pixel_x, pixel_y) is in the visible area
- pixel_x  output  CW  current horizontal position, 0..H_TOTAL-1
- pixel_y  output  CW  current vertical position, 0..V_TOTAL-1
- line_start  output  1  one-clock pulse when pixel_x enters 0
- frame_start  output  1  one-clock pulse when (pixel_x, pixel_y) enters (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset is asynchronous, active-low. While reset_n = 0:
  - pixel_x = 0, pixel_y = 0
  - hsync = ~HS_POL, vsync = ~VS_POL (inactive)
  - video_on = 0, line_start = 0, frame_start = 0
  - FSM = IDLE
- FSM has two states: IDLE and RUN.
  - IDLE: counters held at (0,0), all outputs at reset values. The first clock with pixel_en = 1 moves to RUN. On that edge, outputs take the values for position (0,0): video_on = 1, line_start = 1, frame_start = 1. Counters stay (0,0).
  - RUN: on each clock with pixel_en = 1:
    - pixel_x increments.
    - pixel_x = H_TOTAL-1 wraps to 0; pixel_y increments at the same edge.
    - pixel_y = V_TOTAL-1 with pixel_x wrapping wraps pixel_y to 0.
  - RUN: with pixel_en = 0, all counters and level outputs hold. Pulses deassert.
- All outputs are registered and mutually coherent. On the edge where the counters take value (x,y), hsync, vsync, video_on and the pulses take their values for (x,y) on that same edge. There is no pipeline skew between coordinates and sync.
- hsync = HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~HS_POL.
- vsync = VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~VS_POL. vsync changes only on the edge where x wraps to 0.
- video_on = (x < H_ACTIVE) && (y < V_ACTIVE).
- line_start and frame_start:
  - High for exactly one clock, on the edge entering x = 0 (respectively (0,0)).
  - Low on every other clock, including clocks where the position is held.
- pixel_en is never assumed periodic. Back-to-back strobes (pixel_en held high) advance one pixel per clock. Arbitrary gaps between strobes are legal.
- Reset asserted mid-frame returns everything to reset values immediately (asynchronous). After release, the block waits in IDLE for the next pixel_en.
- Counter arithmetic is unsigned CW-bit. CW must hold H_TOTAL-1 and V_TOTAL-1. No other saturation logic exists.

Test Plan:
- Reset check: reset_n = 0 with random pixel_en -> x = 0, y = 0, hsync = 1, vsync = 1, video_on = 0, no pulses. Release reset, then first pixel_en -> video_on = 1, line_start = 1 and frame_start = 1 for one clock, x = 0.
- Line timing, with pixel_en every 2nd clock (DIVISOR 2 pattern):
  - hsync low exactly for x = 656..751 (96 strobes).
  - video_on falls when x goes 639 -> 640.
  - x = 799 -> 0 increments y; line_start pulses once per 800 strobes.
- Frame timing: run a full frame (420000 strobes = 840000 clocks) -> vsync low only for y = 490..491, y = 524 -> 0, frame_start pulses exactly once per frame, frame period = 16.8 ms.
- Stall: hold pixel_en = 0 for 50 clocks at x = 700 -> x, y, hsync frozen and no pulses; resume -> x = 701 on the next strobe.
- Continuous enable: pixel_en = 1 every clock -> x advances every clock, wrap and sync widths identical in strobe counts.
- Mid-frame reset: assert reset_n = 0 at (x = 300, y = 200) for 3 clocks between edges -> outputs go to reset values without waiting for a clock edge. Frame restarts at (0,0) with frame_start on the first pixel_en after release.
